operand_feeder: RTL
===================

Name: operand_feeder

Overview:
- Streams operand vectors from a local operand buffer into the skew register bank at the edge of the systolic array. Sits directly upstream of the skew bank and drives its packed_din/en.
- On start, reads k_len consecutive N-lane vectors, then emits N-1 zero vectors to drain the skew chain, then pulses done.
- Honours a downstream stall without losing in-flight read data.

Parameters:
- DATA_WIDTH, 16, width of one lane element.
- N, 4, lanes per vector; must match the skew bank and array dimension.
- ADDR_WIDTH, 8, operand buffer address width.
- LEN_WIDTH, 9, width of k_len; allows up to 2^LEN_WIDTH-1 vectors.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first buffer address; captured with start.
- k_len  in  LEN_WIDTH  number of vectors to stream; captured with start.
- stall  in  1  downstream hold; when 1, no new vector is presented.
- rd_en  out  1  buffer read enable.
- rd_addr  out  ADDR_WIDTH  buffer read address.
- rd_data  in  DATA_WIDTH*N  buffer read data, valid exactly 1 cycle after rd_en.
- packed_dout  out  DATA_WIDTH*N  vector to skew bank; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- skew_en  out  1  advance strobe to skew bank; high only when packed_dout is new.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Synchronously clears all registers.
  - rd_en=0, rd_addr=0, packed_dout=0, skew_en=0, busy=0, done=0.
  - Returns to IDLE and clears the skid register.
  - Applies mid-operation too: the stream is abandoned and no done pulse is produced.
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - start=1 with k_len!=0 -> STREAM next cycle; base_addr and k_len are captured.
  - start=1 with k_len=0 -> DONE; no reads are issued.
  - start while busy is ignored.
- STREAM:
  - Each non-stalled cycle issues rd_en=1 at rd_addr = base + issued_count, then increments issued_count.
  - rd_addr wraps modulo 2^ADDR_WIDTH.
  - When issued_count reaches k_len and all reads have been presented -> FLUSH.
- Output register and latency:
  - rd_data is registered into packed_dout with skew_en=1 on the cycle after it returns.
  - Unstalled latency is 2 cycles: rd_en at cycle t -> skew_en at t+2.
- Stall:
  - stall=1 forces rd_en=0 and skew_en=0; packed_dout holds its value.
  - Read data returning during a stall is captured in a one-entry skid register and presented first once stall drops.
  - At most one read is in flight, so the skid register never overflows.
  - stall has no effect in IDLE/DONE.
- FLUSH:
  - Presents N-1 all-zero vectors with skew_en=1, one per non-stalled cycle, then -> DONE.
  - N=1: FLUSH is skipped.
- DONE: done=1 for one cycle, busy=0 -> IDLE. A start in the same cycle is ignored.
- busy is high in STREAM and FLUSH only.
- Simultaneous stall with the last read: the read is still captured and completes normally.

Decomposition:
- Shared package holds:
  - The FSM state typedef (IDLE, STREAM, FLUSH, DONE).
  - Default DATA_WIDTH, N and ADDR_WIDTH constants, shared with the skew bank and PE array.
- One natural sub-module: feeder_skid_buf, the one-entry skid register with valid flag, DATA_WIDTH*N wide.

Test Plan:
- Basic stream (buffer 0x10..0x12 = A, B, C): start at cycle 0 with base=0x10, k_len=3, stall=0.
  - rd_en at cycles 1-3 with rd_addr 0x10, 0x11, 0x12.
  - skew_en at cycles 3-5 carrying A, B, C.
  - Zero vectors at cycles 6-8; done at cycle 9; busy high in cycles 1-8.
- Stall: same stimulus with stall=1 in cycles 3-4.
  - No rd_en and no skew_en during the stall.
  - A, B, C presented in order with none lost or duplicated; done delayed by exactly 2 cycles.
- Zero length: start with k_len=0 -> no rd_en, done at cycle 1, busy never high.
- Address wrap: base=0xFE, k_len=4 -> rd_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-stream: rst_n=0 at cycle 4 of the basic run.
  - Next cycle all outputs are 0 and the FSM is in IDLE; no done pulse.
  - A subsequent start then behaves exactly as the basic stream case.
- Start while busy: a second start at cycle 2 is ignored; only one done pulse, at cycle 9.

Source files
------------

// File: rtl/operand_feeder_pkg.sv
// Shared definitions for the operand feeder, skew bank and PE array slice.
// Holds the default geometry and the feeder FSM state encoding.
package operand_feeder_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_N          = 4;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_LEN_WIDTH  = 9;

   typedef logic [1:0] feeder_state_t;

   localparam feeder_state_t ST_IDLE   = 2'd0;
   localparam feeder_state_t ST_STREAM = 2'd1;
   localparam feeder_state_t ST_FLUSH  = 2'd2;
   localparam feeder_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/feeder_skid_buf.sv
// One-entry skid register holding a returned read vector while the
// downstream skew bank is stalled.
module feeder_skid_buf
   import operand_feeder_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH * DEF_N
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             vld
);

   logic [WIDTH-1:0] data_q;
   logic             vld_q;

   // load wins over drain so a refill in the same cycle keeps the entry valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         vld_q  <= 1'b0;
      end else if (load) begin
         data_q <= din;
         vld_q  <= 1'b1;
      end else if (drain) begin
         vld_q  <= 1'b0;
      end
   end

   assign dout = data_q;
   assign vld  = vld_q;

endmodule

// File: rtl/operand_feeder.sv
// Streams k_len operand vectors from the operand buffer into the skew bank,
// then N-1 zero vectors to drain the skew chain, then pulses done.
module operand_feeder
   import operand_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int N          = DEF_N,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [LEN_WIDTH-1:0]    k_len,
   input  logic                    stall,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH*N-1:0] rd_data,
   output logic [DATA_WIDTH*N-1:0] packed_dout,
   output logic                    skew_en,
   output logic                    busy,
   output logic                    done
);

   localparam int VW = DATA_WIDTH * N;
   localparam int FW = (N > 1) ? $clog2(N) : 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 1);

   feeder_state_t         state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  issued_q;
   logic [FW-1:0]         flush_cnt_q;

   logic                  rd_vld_p1;
   logic [VW-1:0]         out_data_p2;
   logic                  out_vld_p2;

   logic [VW-1:0]         skid_data;
   logic                  skid_vld;
   logic                  skid_load;
   logic                  skid_drain;

   logic                  rd_go;
   logic                  present;
   logic                  out_free;
   logic                  all_read;

   always_comb begin
      rd_go      = (state_q == ST_STREAM) && !stall && (issued_q != len_q);
      present    = out_vld_p2 && !stall;
      out_free   = !out_vld_p2 || present;
      all_read   = (issued_q == len_q) && !rd_vld_p1 && !skid_vld;
      skid_load  = rd_vld_p1 && (!out_free || skid_vld);
      skid_drain = out_free && skid_vld;
   end

   feeder_skid_buf #(
      .WIDTH (VW)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .drain (skid_drain),
      .din   (rd_data),
      .dout  (skid_data),
      .vld   (skid_vld)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         flush_cnt_q <= '0;
         rd_vld_p1   <= 1'b0;
         out_data_p2 <= '0;
         out_vld_p2  <= 1'b0;
      end else begin
         // p0 -> p1: read issued this cycle returns data next cycle
         rd_vld_p1 <= rd_go;
         if (rd_go) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            issued_q <= issued_q + LEN_WIDTH'(1);
         end

         // p1 -> p2: the skid entry is older than the read arriving now
         if (out_free) begin
            if (skid_vld) begin
               out_data_p2 <= skid_data;
               out_vld_p2  <= 1'b1;
            end else if (rd_vld_p1) begin
               out_data_p2 <= rd_data;
               out_vld_p2  <= 1'b1;
            end else begin
               out_vld_p2  <= 1'b0;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q   <= base_addr;
                  len_q    <= k_len;
                  issued_q <= '0;
                  state_q  <= (k_len == '0) ? ST_DONE : ST_STREAM;
               end
            end
            ST_STREAM: begin
               // first zero vector is preloaded so it follows the last read without a bubble
               if (all_read && out_free) begin
                  if (N > 1) begin
                     state_q     <= ST_FLUSH;
                     out_data_p2 <= '0;
                     out_vld_p2  <= 1'b1;
                     flush_cnt_q <= FW'(1);
                  end else begin
                     state_q     <= ST_DONE;
                  end
               end
            end
            ST_FLUSH: begin
               if (present) begin
                  if (flush_cnt_q == FLUSH_LAST) begin
                     state_q     <= ST_DONE;
                  end else begin
                     out_data_p2 <= '0;
                     out_vld_p2  <= 1'b1;
                     flush_cnt_q <= flush_cnt_q + FW'(1);
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_en       = rd_go;
   assign rd_addr     = addr_q;
   assign packed_dout = out_data_p2;
   assign skew_en     = present;
   assign busy        = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
   assign done        = (state_q == ST_DONE);

endmodule
